// File: rtl/arbitro_sumador_pkg.sv
// Shared types and constants for the arbitrated 64-bit adder.
package arbitro_sumador_pkg;

  localparam int ANCHO_DATO = 64;

  typedef logic [ANCHO_DATO-1:0] dato_t;

  typedef enum logic {VACIO, LLENO} estado_t;

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin grant: first requester at or after ptr, modulo NREQ.
module arbitro_rr #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  logic [IDW-1:0] idx;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sumador_64_bit.sv
// Plain 64-bit adder with carry-in and carry-out.
module sumador_64_bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/arbitro_sumador_64.sv
// Round-robin arbiter sharing one 64-bit adder among NREQ requesters,
// with a single registered result slot and a completed-transfer counter.
module arbitro_sumador_64
  import arbitro_sumador_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][ANCHO_DATO-1:0]  req_a,
  input  logic [NREQ-1:0][ANCHO_DATO-1:0]  req_b,
  input  logic [NREQ-1:0]                  req_cin,
  output logic                             res_valid,
  input  logic                             res_ready,
  output dato_t                            res_sum,
  output logic                             res_cout,
  output logic [IDW-1:0]                   res_id,
  output logic [31:0]                      ops_count
);

  estado_t        estado;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_next;
  logic [31:0]    ops_count_q;
  logic           can_accept;
  logic [NREQ-1:0] req_gated;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0] grant_idx;
  logic           any_grant;
  dato_t          add_a, add_b, add_sum;
  logic           add_cin, add_cout;

  assign res_valid  = (estado == LLENO);
  assign can_accept = (estado == VACIO) || res_ready;
  // Gating with rst_n keeps req_ready low for the whole reset, not just after an edge.
  assign req_gated  = req_valid & {NREQ{can_accept && rst_n}};
  assign req_ready  = grant;
  assign ops_count  = ops_count_q;
  assign ptr_next   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  arbitro_rr #(.NREQ(NREQ), .IDW(IDW)) u_arbitro_rr (
    .req       (req_gated),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (any_grant) begin
      add_a   = req_a[grant_idx];
      add_b   = req_b[grant_idx];
      add_cin = req_cin[grant_idx];
    end
  end

  sumador_64_bit u_sumador_64_bit (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= VACIO;
      ptr         <= '0;
      res_sum     <= '0;
      res_cout    <= 1'b0;
      res_id      <= '0;
      ops_count_q <= '0;
    end else begin
      if (any_grant) begin
        res_sum  <= add_sum;
        res_cout <= add_cout;
        res_id   <= grant_idx;
        ptr      <= ptr_next;
      end
      case (estado)
        VACIO: if (any_grant) estado <= LLENO;
        LLENO: begin
          if (res_ready) begin
            ops_count_q <= ops_count_q + 32'd1;
            if (!any_grant) estado <= VACIO;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_sumador_64.sv
// Directed bench for arbitro_sumador_64 with NREQ=4.
module tb_arbitro_sumador_64;

  localparam int NREQ = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][63:0] req_a;
  logic [NREQ-1:0][63:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  res_valid;
  logic                  res_ready;
  logic [63:0]           res_sum;
  logic                  res_cout;
  logic [1:0]            res_id;
  logic [31:0]           ops_count;

  int passed = 0;
  int total  = 0;
  int proto_errs = 0;

  always #5 clk = ~clk;

  arbitro_sumador_64 #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .ops_count (ops_count)
  );

  // Requester-side protocol monitor: operands must hold while waiting for a grant.
  logic [NREQ-1:0]       pend;
  logic [NREQ-1:0][63:0] pa, pb;
  logic [NREQ-1:0]       pc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && req_valid[i] &&
            (req_a[i] !== pa[i] || req_b[i] !== pb[i] || req_cin[i] !== pc[i])) begin
          proto_errs <= proto_errs + 1;
          $display("FAIL proto_stable req%0d: operands changed while waiting for grant", i);
        end
      end
      pend <= req_valid & ~req_ready;
      pa   <= req_a;
      pb   <= req_b;
      pc   <= req_cin;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    res_ready = 1'b1;
    #1;
    total++; if (res_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", res_valid); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
    total++; if (ops_count !== 32'd0) $display("FAIL reset_ops: got %0d want 0", ops_count); else passed++;
    total++; if (res_sum !== 64'd0 || res_cout !== 1'b0 || res_id !== 2'd0)
      $display("FAIL reset_result: got sum=%h cout=%b id=%0d want 0/0/0", res_sum, res_cout, res_id);
    else passed++;
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    req_a[2]   = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b[2]   = 64'h1;
    req_cin[2] = 1'b0;
    req_valid  = 4'b0100;
    res_ready  = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready); else passed++;
    tick();
    req_valid = '0;
    total++; if (res_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", res_valid); else passed++;
    total++; if (res_sum !== 64'd0) $display("FAIL single_sum: got %h want 0", res_sum); else passed++;
    total++; if (res_cout !== 1'b1) $display("FAIL single_cout: got %b want 1", res_cout); else passed++;
    total++; if (res_id !== 2'd2) $display("FAIL single_id: got %0d want 2", res_id); else passed++;
    tick();
    total++; if (ops_count !== 32'd1) $display("FAIL single_ops: got %0d want 1", ops_count); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", res_valid); else passed++;
    total++; if (res_id !== 2'd2 || res_sum !== 64'd0)
      $display("FAIL single_hold: got id=%0d sum=%h want 2/0", res_id, res_sum);
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [64:0] t;
    int          g;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i]   = 64'hA0 + 64'(i);
      req_b[i]   = 64'h100 << i;
      req_cin[i] = i[0];
    end
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      g = k % NREQ;
      #1;
      total++; if (req_ready !== (4'b0001 << g)) $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'b0001 << g); else passed++;
      tick();
      t = {1'b0, req_a[g]} + {1'b0, req_b[g]} + 65'(req_cin[g]);
      total++; if (res_valid !== 1'b1 || res_id !== 2'(g))
        $display("FAIL rr_id%0d: got valid=%b id=%0d want 1/%0d", k, res_valid, res_id, g);
      else passed++;
      total++; if (res_sum !== t[63:0]) $display("FAIL rr_sum%0d: got %h want %h", k, res_sum, t[63:0]); else passed++;
    end
    req_valid = '0;
    total++; if (ops_count !== 32'd5) $display("FAIL rr_ops_mid: got %0d want 5", ops_count); else passed++;
    tick();
    total++; if (ops_count !== 32'd6) $display("FAIL rr_ops: got %0d want 6", ops_count); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", res_valid); else passed++;
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_a[1] = 64'd5;   req_b[1] = 64'd7;   req_cin[1] = 1'b1;
    req_a[3] = 64'd100; req_b[3] = 64'd200; req_cin[3] = 1'b0;
    req_valid = 4'b1010;
    res_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) $display("FAIL bp_grant1: got %b want 0010", req_ready); else passed++;
    tick();
    req_valid = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); else passed++;
      total++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_sum !== 64'd13 || res_cout !== 1'b0)
        $display("FAIL bp_hold%0d: got valid=%b id=%0d sum=%0d cout=%b want 1/1/13/0",
                 c, res_valid, res_id, res_sum, res_cout);
      else passed++;
      tick();
    end
    res_ready = 1'b1;
    #1;
    total++; if (req_ready !== 4'b1000) $display("FAIL bp_grant3: got %b want 1000", req_ready); else passed++;
    tick();
    req_valid = '0;
    total++; if (res_valid !== 1'b1 || res_id !== 2'd3 || res_sum !== 64'd300)
      $display("FAIL bp_next: got valid=%b id=%0d sum=%0d want 1/3/300", res_valid, res_id, res_sum);
    else passed++;
    total++; if (ops_count !== 32'd1) $display("FAIL bp_ops1: got %0d want 1", ops_count); else passed++;
    tick();
    total++; if (ops_count !== 32'd2 || res_valid !== 1'b0)
      $display("FAIL bp_ops2: got ops=%0d valid=%b want 2/0", ops_count, res_valid);
    else passed++;
  endtask

  task automatic test_carry_halves();
    apply_reset();
    req_a[0]   = 64'h0000_0000_FFFF_FFFF;
    req_b[0]   = 64'h0;
    req_cin[0] = 1'b1;
    req_valid  = 4'b0001;
    res_ready  = 1'b1;
    tick();
    req_valid = '0;
    total++; if (res_sum !== 64'h0000_0001_0000_0000) $display("FAIL carry_sum: got %h want 0000000100000000", res_sum); else passed++;
    total++; if (res_cout !== 1'b0 || res_id !== 2'd0)
      $display("FAIL carry_cout: got cout=%b id=%0d want 0/0", res_cout, res_id);
    else passed++;
    tick();
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    force dut.ops_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.ops_count_q;
    total++; if (ops_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h want ffffffff", ops_count); else passed++;
    req_a[1]   = 64'd3;
    req_b[1]   = 64'd4;
    req_cin[1] = 1'b0;
    req_valid  = 4'b0010;
    res_ready  = 1'b1;
    tick();
    req_valid = '0;
    total++; if (res_sum !== 64'd7 || res_id !== 2'd1 || res_valid !== 1'b1)
      $display("FAIL wrap_result: got sum=%0d id=%0d valid=%b want 7/1/1", res_sum, res_id, res_valid);
    else passed++;
    tick();
    total++; if (ops_count !== 32'd0) $display("FAIL wrap_ops: got %h want 0", ops_count); else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_a[0]   = 64'd1;
    req_b[0]   = 64'd1;
    req_cin[0] = 1'b0;
    req_valid  = 4'b0001;
    res_ready  = 1'b1;
    tick();
    tick();
    res_ready = 1'b0;
    #1;
    total++; if (res_valid !== 1'b1 || ops_count !== 32'd1 || res_sum !== 64'd2)
      $display("FAIL mid_pre: got valid=%b ops=%0d sum=%0d want 1/1/2", res_valid, ops_count, res_sum);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if (res_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", res_valid); else passed++;
    total++; if (ops_count !== 32'd0) $display("FAIL mid_ops: got %0d want 0", ops_count); else passed++;
    total++; if (req_ready !== 4'b0000) $display("FAIL mid_ready: got %b want 0000", req_ready); else passed++;
    total++; if (res_sum !== 64'd0) $display("FAIL mid_sum: got %h want 0", res_sum); else passed++;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_carry_halves();
    test_counter_wrap();
    test_reset_mid();
    tick();
    total++; if (proto_errs !== 0) $display("FAIL proto_errors: got %0d want 0", proto_errs); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbitro_sumador_64.md
Name: arbitro_sumador_64

Overview:
- Shares a single sumador_64_bit instance between NREQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on every request port and on the result port.
- Each accepted request is added once (a + b + cin) and returned through one registered result slot, tagged with the requester index.
- Sits between the processing units and the shared 64-bit adder; it is the only block that drives the adder inputs.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester index (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- req_a  in  NREQ x 64  operand A per requester.
- req_b  in  NREQ x 64  operand B per requester.
- req_cin  in  NREQ  carry-in per requester.
- res_valid  out  1  result slot holds a valid result.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  64  registered sum.
- res_cout  out  1  registered carry-out.
- res_id  out  IDW  index of the requester that owns the result.
- ops_count  out  32  number of completed result transfers; wraps at 2^32.

Behaviour:
- Reset (rst_n low, asynchronous):
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, ops_count=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
  - req_ready is all zero while rst_n is low.
  - Reset asserted mid-operation discards the held result with no handshake.
- Slot state machine, two states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
  - can_accept = EMPTY, or FULL with res_ready=1. A drain and a refill may happen in the same cycle.
- Arbitration (combinational, every cycle):
  - If can_accept, grant the first i with req_valid[i]=1, searching from ptr upward modulo NREQ.
  - req_ready is one-hot for that i, or zero if there is no request or no slot.
  - At most one grant per cycle.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Datapath:
  - The adder inputs are muxed from the granted requester: a=req_a[g], b=req_b[g], cin=req_cin[g].
  - With no grant, the adder inputs are 0.
- On a request transfer at edge N:
  - res_sum/res_cout capture the adder outputs.
  - res_id=g, res_valid=1 at N+1.
  - Latency is one cycle from acceptance to res_valid.
- Pointer update: on a grant to g, ptr becomes (g+1) mod NREQ. Otherwise ptr holds.
- Result transfer and stability:
  - A result transfers when res_valid=1 and res_ready=1.
  - Transfer with no new grant: FULL→EMPTY, res_valid=0 next cycle. res_sum, res_cout and res_id keep their last values.
  - While res_valid=1 and res_ready=0, res_sum, res_cout and res_id hold stable and all req_ready are 0.
- Throughput: one result per cycle when res_ready is held high.
- ops_count increments by 1 on each result transfer. 0xFFFF_FFFF wraps to 0.
- Arithmetic:
  - Full 64-bit modular sum; overflow is reported only through res_cout.
  - No signed interpretation.
- Fairness: any requester holding req_valid high is granted within NREQ grants.
- Requester protocol: req_a, req_b and req_cin must stay stable while req_valid=1 and req_ready=0. The bench flags violations; the RTL does not check them.

Decomposition:
- Package arbitro_sumador_pkg holds:
  - constant ANCHO_DATO=64;
  - typedef dato_t (logic [63:0]);
  - typedef enum estado_t {VACIO, LLENO}.
- Sub-module arbitro_rr: parameterised round-robin grant logic (req vector, ptr → one-hot grant, index, any_grant), combinational.
- The pointer register stays in the top module.
- sumador_64_bit is instantiated unchanged in the top module.

Test Plan:
- Reset mid-result: rst_n low while FULL → res_valid=0, ops_count=0 and req_ready=0 immediately, without waiting for a clock edge.
- Single request: req 2 with a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0, res_ready=1 → res_valid one cycle later, res_sum=0, res_cout=1, res_id=2, ops_count=1.
- Round robin: all 4 requesters valid continuously, res_ready=1 → grants 0,1,2,3,0,1… one per cycle; ops_count=6 after 6 results.
- Backpressure: res_ready=0 with requesters 1 and 3 valid → one result (id 1, a=5, b=7, cin=1, sum=13) held stable for 10 cycles with all req_ready=0. Raising res_ready yields id 3 the next cycle.
- Carry across halves: a=0x0000_0000_FFFF_FFFF, b=0x0, cin=1 → res_sum=0x0000_0001_0000_0000, res_cout=0.
- Counter wrap: force or preload to 0xFFFF_FFFF transfers, then complete one more → ops_count=0, and results are otherwise unaffected.
